// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide unit with HI/LO registers.
// The result is computed when the op is accepted and held in a pending
// register; it is committed to HI/LO only when the busy count expires, so a
// flush simply drops it.
// Optional feature macro: MDU_MADD_EN enables MADD (op 6) and MSUB (op 7).
module mul_div_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] pend;
  logic [2*WIDTH-1:0] res_nxt;
  logic               accept, mt_wr, finish;
  logic               is_mul, is_div, is_mt;

  // op classes; MADD/MSUB only count as multiplies when the feature is built in
  assign is_div = (op == 3'd2) || (op == 3'd3);
  assign is_mt  = (op == 3'd4) || (op == 3'd5);
`ifdef MDU_MADD_EN
  assign is_mul = (op == 3'd0) || (op == 3'd1) || (op == 3'd6) || (op == 3'd7);
`else
  assign is_mul = (op == 3'd0) || (op == 3'd1);
`endif

  assign busy = (state == BUSY);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next state and control strobes; flush outranks everything
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    mt_wr     = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          if (is_mul || is_div) begin
            accept    = 1'b1;
            state_nxt = BUSY;
          end else if (is_mt) begin
            mt_wr = 1'b1;
          end
        end
      end
      BUSY: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (cnt == CW'(1)) begin
          state_nxt = IDLE;
          finish    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  logic [2*WIDTH-1:0] prod_s, prod_u, cur;
  logic [WIDTH-1:0]   abs_a, abs_b, abs_b_safe, b_safe;
  logic [WIDTH-1:0]   uq, ur, sq, sr, dq, dr;
  logic               b_zero;

  assign cur    = {hi, lo};
  assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // signed divide via magnitudes: quotient sign = sign(a)^sign(b), remainder
  // follows the dividend. min-neg / -1 falls out as q=min-neg, r=0 naturally.
  // A zero divisor is replaced by 1 only to keep the operator defined; the
  // result is discarded in that case.
  assign b_zero     = (b == '0);
  assign abs_a      = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
  assign abs_b      = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
  assign abs_b_safe = b_zero ? WIDTH'(1) : abs_b;
  assign b_safe     = b_zero ? WIDTH'(1) : b;
  assign uq         = abs_a / abs_b_safe;
  assign ur         = abs_a % abs_b_safe;
  assign sq         = (a[WIDTH-1] ^ b[WIDTH-1]) ? (~uq + WIDTH'(1)) : uq;
  assign sr         = a[WIDTH-1] ? (~ur + WIDTH'(1)) : ur;
  assign dq         = a / b_safe;
  assign dr         = a % b_safe;

  // result to be committed at completion; divide-by-zero recommits current HI/LO
  always_comb begin
    res_nxt = cur;
    case (op)
      3'd0: res_nxt = prod_s;
      3'd1: res_nxt = prod_u;
      3'd2: res_nxt = b_zero ? cur : {sr, sq};
      3'd3: res_nxt = b_zero ? cur : {dr, dq};
`ifdef MDU_MADD_EN
      3'd6: res_nxt = cur + prod_s;
      3'd7: res_nxt = cur - prod_s;
`endif
      default: res_nxt = cur;
    endcase
  end

  // busy countdown, loaded on accept and cleared on completion or flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
    end else if (state == BUSY) begin
      if (flush || cnt == CW'(1)) cnt <= '0;
      else                        cnt <= cnt - CW'(1);
    end
  end

  // pending result captured at the accept edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       pend <= '0;
    else if (accept) pend <= res_nxt;
  end

  // HI/LO: commit pending result on completion, or direct MTHI/MTLO write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (finish) begin
      {hi, lo} <= pend;
    end else if (mt_wr) begin
      if (op == 3'd4) hi <= a;
      else            lo <= a;
    end
  end

endmodule
